// File: rtl/serial_to_parallel_rx.sv
// serial_to_parallel_rx
// ---------------------
// Receive-side deserialiser. It collects a serial bit stream into
// DATA_WIDTH-bit words, taking one bit on each cycle where bit_valid is high.
// A one-word holding buffer with a valid/ready handshake lets the next frame
// be received while the consumer still holds the current word.
//
// Optional feature: define S2P_PARITY_EN to add one even-parity bit after the
// data bits of every frame. This also adds the parity_err output.
//
// Ports:
//   clk              in   clock; all logic is on the rising edge
//   rst              in   synchronous reset, active-high
//   serial_in        in   serial data bit
//   bit_valid        in   qualifies serial_in for this cycle
//   abort            in   drops the partial frame and returns to IDLE
//   clr_ovf          in   clears the sticky overflow flag
//   word_ready       in   consumer accepts word_out this cycle
//   word_out         out  assembled word
//   word_valid       out  word_out holds a word that has not been consumed
//   end_of_reception out  one-cycle pulse when a frame completes
//   busy             out  a frame is in progress (state RECV)
//   overflow         out  sticky: a completed word was dropped
//   bit_count        out  number of bits received in the current frame
//   parity_err       out  (S2P_PARITY_EN only) parity mismatch, valid with word_valid
module serial_to_parallel_rx #(
  parameter int DATA_WIDTH = 16,
  parameter bit MSB_FIRST  = 1'b1,
`ifdef S2P_PARITY_EN
  localparam int FRAME_LEN = DATA_WIDTH + 1,
`else
  localparam int FRAME_LEN = DATA_WIDTH,
`endif
  localparam int CNT_W = $clog2(FRAME_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  serial_in,
  input  logic                  bit_valid,
  input  logic                  abort,
  input  logic                  clr_ovf,
  input  logic                  word_ready,
  output logic [DATA_WIDTH-1:0] word_out,
  output logic                  word_valid,
  output logic                  end_of_reception,
  output logic                  busy,
  output logic                  overflow,
  output logic [CNT_W-1:0]      bit_count
`ifdef S2P_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  typedef enum logic {IDLE, RECV} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  valid_q, valid_d;
  logic                  eor_q, eor_d;
  logic                  ovf_q, ovf_d;
`ifdef S2P_PARITY_EN
  logic                  perr_q, perr_d;
  logic                  perr_new;
`endif

  logic [DATA_WIDTH-1:0] sreg_shift;
  logic [DATA_WIDTH-1:0] word_new;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  frame_done;

  always_comb begin
    if (MSB_FIRST) sreg_shift = {sreg_q[DATA_WIDTH-2:0], serial_in};
    else           sreg_shift = {serial_in, sreg_q[DATA_WIDTH-1:1]};
  end

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    valid_d    = valid_q;
    ovf_d      = ovf_q;
    eor_d      = 1'b0;
    frame_done = 1'b0;
`ifdef S2P_PARITY_EN
    perr_d     = perr_q;
    // On the parity edge the data register already holds the whole word.
    word_new   = sreg_q;
    perr_new   = ^{sreg_q, serial_in};
`else
    // The final data bit has to be part of the word loaded on this edge.
    word_new   = sreg_shift;
`endif

    // Bit capture. abort overrides any bit_valid seen in the same cycle.
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (bit_valid) begin
`ifdef S2P_PARITY_EN
      // The parity bit is not shifted into the data register.
      if (cnt_q < CNT_W'(DATA_WIDTH)) sreg_d = sreg_shift;
`else
      sreg_d = sreg_shift;
`endif
      if (cnt_inc == CNT_W'(FRAME_LEN)) begin
        frame_done = 1'b1;
        cnt_d      = '0;
        state_d    = IDLE;
      end else begin
        cnt_d   = cnt_inc;
        state_d = RECV;
      end
    end

    // clr_ovf is applied first so that a drop in the same cycle wins.
    if (clr_ovf) ovf_d = 1'b0;

    // Holding buffer. A consume and a load in the same cycle count as a transfer.
    if (frame_done) begin
      eor_d = 1'b1;
      if (!valid_q || word_ready) begin
        word_d  = word_new;
        valid_d = 1'b1;
`ifdef S2P_PARITY_EN
        perr_d  = perr_new;
`endif
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      eor_q   <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef S2P_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      eor_q   <= eor_d;
      ovf_q   <= ovf_d;
`ifdef S2P_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign word_out         = word_q;
  assign word_valid       = valid_q;
  assign end_of_reception = eor_q;
  assign busy             = (state_q == RECV);
  assign overflow         = ovf_q;
  assign bit_count        = cnt_q;
`ifdef S2P_PARITY_EN
  assign parity_err       = perr_q;
`endif

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Testbench for serial_to_parallel_rx with the default parameters
// (DATA_WIDTH=16, MSB_FIRST=1). At every end_of_reception pulse a monitor
// pops the next expected result from the scoreboard queue and checks
// word_out, word_valid and overflow against it. Directed checks cover the
// reset state, busy and bit_count.
module tb_serial_to_parallel_rx;

`ifdef S2P_PARITY_EN
  localparam int FRAME = 17;
`else
  localparam int FRAME = 16;
`endif

  logic        clk = 1'b0;
  logic        rst, serial_in, bit_valid, abort, clr_ovf, word_ready;
  logic [15:0] word_out;
  logic        word_valid, end_of_reception, busy, overflow;
  logic [4:0]  bit_count;
`ifdef S2P_PARITY_EN
  logic        parity_err;
`endif

  typedef struct {
    logic [15:0] word;
    logic        ovf;
    logic        perr;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_to_parallel_rx dut (
    .clk              (clk),
    .rst              (rst),
    .serial_in        (serial_in),
    .bit_valid        (bit_valid),
    .abort            (abort),
    .clr_ovf          (clr_ovf),
    .word_ready       (word_ready),
    .word_out         (word_out),
    .word_valid       (word_valid),
    .end_of_reception (end_of_reception),
    .busy             (busy),
    .overflow         (overflow),
    .bit_count        (bit_count)
`ifdef S2P_PARITY_EN
    ,
    .parity_err       (parity_err)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Scoreboard monitor: one pop and compare per completed frame.
  always @(negedge clk) begin
    if (!rst && end_of_reception) begin
      if (exp_q.size() == 0) begin
        chk("eor_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_word_out", {16'd0, word_out}, {16'd0, e.word});
        chk("sb_word_valid", {31'd0, word_valid}, 32'd1);
        chk("sb_overflow", {31'd0, overflow}, {31'd0, e.ovf});
`ifdef S2P_PARITY_EN
        chk("sb_parity_err", {31'd0, parity_err}, {31'd0, e.perr});
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
  endtask

  // Sends up to 16 data bits MSB first, then the parity bit if the feature
  // is enabled. With gaps > 0 the bench idles for that many cycles after
  // each bit and checks that bit_count holds its value.
  task automatic send_word(input logic [15:0] w, input int gaps, input int nbits, input logic par);
    for (int i = 0; i < nbits; i++) begin
      send_bit(w[15-i]);
      if (gaps > 0) begin
        repeat (gaps) tick();
        chk($sformatf("gap_bit_count_%0d", i), {27'd0, bit_count}, (i + 1) % FRAME);
      end
    end
`ifdef S2P_PARITY_EN
    if (nbits == 16) send_bit(par);
`else
    if (par) chk("par_unused", 32'd0, 32'd0);
`endif
  endtask

  function automatic exp_t mk(input logic [15:0] w, input logic o, input logic p);
    exp_t e;
    e.word = w;
    e.ovf  = o;
    e.perr = p;
    return e;
  endfunction

  initial begin
    rst = 1'b1; serial_in = 1'b0; bit_valid = 1'b0; abort = 1'b0;
    clr_ovf = 1'b0; word_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_word_out", {16'd0, word_out}, 32'h0);
    chk("rst_word_valid", {31'd0, word_valid}, 32'd0);
    chk("rst_eor", {31'd0, end_of_reception}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_bit_count", {27'd0, bit_count}, 32'd0);

    // 1: contiguous frame 0xA5C3
    exp_q.push_back(mk(16'hA5C3, 1'b0, 1'b0));
    send_bit(1'b1);
    chk("t1_busy_after_first", {31'd0, busy}, 32'd1);
    chk("t1_bit_count_1", {27'd0, bit_count}, 32'd1);
    send_word(16'h4B86, 0, 15, 1'b0);  // remaining 15 bits of 0xA5C3
`ifdef S2P_PARITY_EN
    send_bit(^16'hA5C3);
`endif
    chk("t1_word_out", {16'd0, word_out}, 32'hA5C3);
    chk("t1_word_valid", {31'd0, word_valid}, 32'd1);
    chk("t1_eor", {31'd0, end_of_reception}, 32'd1);
    chk("t1_busy_done", {31'd0, busy}, 32'd0);
    tick();
    chk("t1_eor_one_cycle", {31'd0, end_of_reception}, 32'd0);
    chk("t1_consumed", {31'd0, word_valid}, 32'd0);

    // 2: 0x1234 with 1-on/2-off gaps
    exp_q.push_back(mk(16'h1234, 1'b0, 1'b0));
    send_word(16'h1234, 2, 16, ^16'h1234);
    chk("t2_word_out", {16'd0, word_out}, 32'h1234);

    // 3: backpressure and overflow
    word_ready = 1'b0;
    exp_q.push_back(mk(16'h00FF, 1'b0, 1'b0));
    send_word(16'h00FF, 0, 16, ^16'h00FF);
    exp_q.push_back(mk(16'h00FF, 1'b1, 1'b0));
    send_word(16'hFF00, 0, 16, ^16'hFF00);
    tick();
    chk("t3_word_held", {16'd0, word_out}, 32'h00FF);
    chk("t3_overflow", {31'd0, overflow}, 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t3_ovf_cleared", {31'd0, overflow}, 32'd0);
    exp_q.push_back(mk(16'hBEEF, 1'b0, 1'b0));
`ifdef S2P_PARITY_EN
    send_word(16'hBEEF, 0, 16, 1'b0);
    word_ready = 1'b1;
    send_bit(^16'hBEEF);
`else
    send_word(16'hBEEF, 0, 15, 1'b0);
    word_ready = 1'b1;
    send_bit(1'b1);  // last bit of 0xBEEF, on the same cycle word_ready rises
`endif
    chk("t3_beef", {16'd0, word_out}, 32'hBEEF);
    chk("t3_no_ovf", {31'd0, overflow}, 32'd0);
    tick();

    // 4: abort after 7 bits, with bit_valid high in the abort cycle
    send_word(16'hFE00, 0, 7, 1'b0);
    chk("t4_bit_count_7", {27'd0, bit_count}, 32'd7);
    abort = 1'b1;
    send_bit(1'b1);
    abort = 1'b0;
    chk("t4_abort_count", {27'd0, bit_count}, 32'd0);
    chk("t4_abort_busy", {31'd0, busy}, 32'd0);
    exp_q.push_back(mk(16'h8001, 1'b0, 1'b0));
    send_word(16'h8001, 0, 16, ^16'h8001);
    chk("t4_word_out", {16'd0, word_out}, 32'h8001);
    tick();

    // 5: reset at bit 10 with a word buffered
    word_ready = 1'b0;
    exp_q.push_back(mk(16'h1111, 1'b0, 1'b0));
    send_word(16'h1111, 0, 16, ^16'h1111);
    send_word(16'hFFFF, 0, 10, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_word_out", {16'd0, word_out}, 32'h0);
    chk("t5_word_valid", {31'd0, word_valid}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_bit_count", {27'd0, bit_count}, 32'd0);
    chk("t5_overflow", {31'd0, overflow}, 32'd0);
    word_ready = 1'b1;
    exp_q.push_back(mk(16'h5A5A, 1'b0, 1'b0));
    send_word(16'h5A5A, 0, 16, ^16'h5A5A);
    chk("t5_word_5a5a", {16'd0, word_out}, 32'h5A5A);
    tick();

`ifdef S2P_PARITY_EN
    exp_q.push_back(mk(16'h0003, 1'b0, 1'b0));
    send_word(16'h0003, 0, 16, 1'b0);
    tick();
    exp_q.push_back(mk(16'h0001, 1'b0, 1'b1));
    send_word(16'h0001, 0, 16, 1'b0);
    tick();
`endif

    repeat (3) tick();
    chk("sb_queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
